// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl
// ----------------------------------------------------------------------------
// Hazard, forwarding and stall controller for a 5-stage pipelined CPU.
// It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and
// drives their load-enable, bubble, hold and flush controls. It also drives
// the EX-stage operand forwarding mux selects.
//
// Functions:
//   - Operand forwarding from EX/MEM (first priority) and MEM/WB. Register 0
//     is never forwarded.
//   - Load-use stall: one cycle with PC and IF/ID frozen and a bubble pushed
//     into ID/EX.
//   - Multi-cycle EX sequencer (IDLE/BUSY). It keeps a multi-cycle op in EX
//     for MULTI_LAT cycles by holding ID/EX and bubbling EX/MEM.
//   - Taken-branch squash of IF/ID, ID/EX and EX/MEM. This has the highest
//     priority and aborts any multi-cycle sequence.
//   - Saturating stall and flush performance counters.
//
// Parameters:
//   ADDR_W     register address width
//   MULTI_LAT  total EX occupancy of a multi-cycle op, in cycles (>= 2)
//   CNT_W      performance counter width
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   id_rs_addr_i, id_rt_addr_i       source registers of the ID instruction
//   id_uses_rs_i, id_uses_rt_i       ID instruction really reads rs / rt
//   ex_rs_addr_i, ex_rt_addr_i       source registers held in ID/EX
//   ex_wr_addr_i                     EX destination register
//   ex_reg_write_i, ex_mem_read_i,
//   ex_multi_i                       EX control bits
//   mem_wr_addr_i, mem_reg_write_i   EX/MEM destination and write enable
//   wb_wr_addr_i, wb_reg_write_i     MEM/WB destination and write enable
//   branch_taken_i                   branch resolved taken in MEM
//   fwd_src1_o, fwd_src2_o           00 reg file, 01 EX/MEM, 10 MEM/WB
//   pc_write_o, ifid_write_o         PC and IF/ID load enables
//   idex_bubble_o, idex_hold_o       ID/EX bubble / keep-contents
//   exmem_bubble_o                   EX/MEM bubble
//   ifid_flush_o, idex_flush_o,
//   exmem_flush_o                    stage squash
//   busy_o, ex_done_o                sequencer in BUSY / op completes now
//   stall_cnt_o, flush_cnt_o         saturating performance counters
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int ADDR_W    = 5,
    parameter int MULTI_LAT = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] id_rs_addr_i,
    input  logic [ADDR_W-1:0] id_rt_addr_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic [ADDR_W-1:0] ex_rs_addr_i,
    input  logic [ADDR_W-1:0] ex_rt_addr_i,
    input  logic [ADDR_W-1:0] ex_wr_addr_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_multi_i,
    input  logic [ADDR_W-1:0] mem_wr_addr_i,
    input  logic              mem_reg_write_i,
    input  logic [ADDR_W-1:0] wb_wr_addr_i,
    input  logic              wb_reg_write_i,
    input  logic              branch_taken_i,
    output logic [1:0]        fwd_src1_o,
    output logic [1:0]        fwd_src2_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              idex_bubble_o,
    output logic              idex_hold_o,
    output logic              exmem_bubble_o,
    output logic              ifid_flush_o,
    output logic              idex_flush_o,
    output logic              exmem_flush_o,
    output logic              busy_o,
    output logic              ex_done_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // The sequencer counts the stall cycles still to come after the
    // first one. MULTI_LAT = 2 loads zero and releases in the BUSY cycle.
    localparam int              SEQ_W    = (MULTI_LAT > 2) ? $clog2(MULTI_LAT) : 1;
    localparam logic [SEQ_W-1:0] SEQ_LOAD = SEQ_W'(MULTI_LAT - 2);

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } seq_state_t;

    seq_state_t       r_state;
    logic [SEQ_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    fwd_sel_t w_fwd1;
    fwd_sel_t w_fwd2;
    logic     w_mem_fwd_ok;
    logic     w_wb_fwd_ok;
    logic     w_load_use;
    logic     w_multi_stall;
    logic     w_seq_release;
    logic     w_pc_write;
    logic     w_ifid_write;
    logic     w_idex_bubble;
    logic     w_idex_hold;
    logic     w_exmem_bubble;
    logic     w_flush;
    logic     w_ex_done;

    // ------------------------------------------------------------------
    // Forwarding. A stage may forward only if it writes a register other
    // than r0. The younger EX/MEM result wins over MEM/WB.
    // ------------------------------------------------------------------
    assign w_mem_fwd_ok = mem_reg_write_i && (mem_wr_addr_i != '0);
    assign w_wb_fwd_ok  = wb_reg_write_i  && (wb_wr_addr_i  != '0);

    // NOTE: every signal assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_fwd1 = FWD_RF;
        if (w_mem_fwd_ok && (mem_wr_addr_i == ex_rs_addr_i)) begin
            w_fwd1 = FWD_EXMEM;
        end else if (w_wb_fwd_ok && (wb_wr_addr_i == ex_rs_addr_i)) begin
            w_fwd1 = FWD_MEMWB;
        end

        w_fwd2 = FWD_RF;
        if (w_mem_fwd_ok && (mem_wr_addr_i == ex_rt_addr_i)) begin
            w_fwd2 = FWD_EXMEM;
        end else if (w_wb_fwd_ok && (wb_wr_addr_i == ex_rt_addr_i)) begin
            w_fwd2 = FWD_MEMWB;
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    // A load in EX whose result the ID instruction needs cannot be
    // forwarded in time. Operands the instruction does not read are
    // ignored.
    assign w_load_use = ex_mem_read_i && ex_reg_write_i && (ex_wr_addr_i != '0) &&
                        ((id_uses_rs_i && (ex_wr_addr_i == id_rs_addr_i)) ||
                         (id_uses_rt_i && (ex_wr_addr_i == id_rt_addr_i)));

    // The first cycle of a multi-cycle op stalls while the FSM is still
    // IDLE. The final BUSY cycle (cnt == 0) lets the pipeline advance.
    assign w_multi_stall = ((r_state == ST_IDLE) && ex_multi_i) ||
                           ((r_state == ST_BUSY) && (r_cnt != '0));
    assign w_seq_release = (r_state == ST_BUSY) && (r_cnt == '0);

    // ------------------------------------------------------------------
    // Pipeline controls. Priority: reset, then branch, then multi-cycle,
    // then load-use.
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_write     = 1'b1;
        w_ifid_write   = 1'b1;
        w_idex_bubble  = 1'b0;
        w_idex_hold    = 1'b0;
        w_exmem_bubble = 1'b0;
        w_flush        = 1'b0;
        w_ex_done      = 1'b0;

        if (rst_i) begin
            // The pipeline runs freely while in reset.
        end else if (branch_taken_i) begin
            // The op in EX is on the wrong path, so it never completes.
            w_flush = 1'b1;
        end else if (w_multi_stall) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_idex_hold    = 1'b1;
            w_exmem_bubble = 1'b1;
        end else begin
            w_ex_done = w_seq_release;
            if (w_load_use) begin
                w_pc_write    = 1'b0;
                w_ifid_write  = 1'b0;
                w_idex_bubble = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer and performance counters
    // ------------------------------------------------------------------
    // NOTE: state is written with non-blocking assignments only, and reset
    // is sampled on the clock edge, so the reset is synchronous.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (branch_taken_i) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (ex_multi_i) begin
                            r_state <= ST_BUSY;
                            r_cnt   <= SEQ_LOAD;
                        end
                    end
                    ST_BUSY: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - SEQ_W'(1);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end

            if (!w_pc_write && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (branch_taken_i && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fwd_src1_o     = rst_i ? FWD_RF : w_fwd1;
    assign fwd_src2_o     = rst_i ? FWD_RF : w_fwd2;
    assign pc_write_o     = w_pc_write;
    assign ifid_write_o   = w_ifid_write;
    assign idex_bubble_o  = w_idex_bubble;
    assign idex_hold_o    = w_idex_hold;
    assign exmem_bubble_o = w_exmem_bubble;
    assign ifid_flush_o   = w_flush;
    assign idex_flush_o   = w_flush;
    assign exmem_flush_o  = w_flush;
    assign busy_o         = !rst_i && (r_state == ST_BUSY);
    assign ex_done_o      = w_ex_done;
    assign stall_cnt_o    = r_stall_cnt;
    assign flush_cnt_o    = r_flush_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and stall controller for the 5-stage pipelined CPU. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their write-enable, bubble and flush controls. It also drives the operand-forwarding mux selects. Beyond plain forwarding it adds:
- load-use stall detection;
- a multi-cycle EX-stage stall sequencer;
- taken-branch squash;
- saturating performance counters.

## Interface
Parameters:
- ADDR_W, 5, register address width.
- MULTI_LAT, 4, total EX occupancy of a multi-cycle op in cycles; legal range is 2 and above.
- CNT_W, 16, width of each performance counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- id_rs_addr_i, id_rt_addr_i  in  ADDR_W  source registers of the instruction in ID.
- id_uses_rs_i, id_uses_rt_i  in  1  the ID instruction actually reads rs / rt.
- ex_rs_addr_i, ex_rt_addr_i  in  ADDR_W  source registers held in ID/EX.
- ex_wr_addr_i  in  ADDR_W  destination register in EX.
- ex_reg_write_i, ex_mem_read_i, ex_multi_i  in  1  EX-stage control bits.
- mem_wr_addr_i  in  ADDR_W, mem_reg_write_i  in  1  EX/MEM destination register and write enable.
- wb_wr_addr_i  in  ADDR_W, wb_reg_write_i  in  1  MEM/WB destination register and write enable.
- branch_taken_i  in  1  branch resolved taken in MEM.
- fwd_src1_o, fwd_src2_o  out  2  forwarding selects: 00 register file, 01 EX/MEM, 10 MEM/WB; 11 is never driven.
- pc_write_o, ifid_write_o  out  1  PC and IF/ID load enables.
- idex_bubble_o  out  1  load zeros into the ID/EX control field.
- idex_hold_o  out  1  ID/EX keeps its contents.
- exmem_bubble_o  out  1  load zeros into the EX/MEM control field.
- ifid_flush_o, idex_flush_o, exmem_flush_o  out  1  squash the stage.
- busy_o  out  1  multi-cycle sequencer is in BUSY.
- ex_done_o  out  1  multi-cycle op completes this cycle.
- stall_cnt_o, flush_cnt_o  out  CNT_W  performance counters.

## Operation
Forwarding (combinational):
- fwd_src1_o = 01 if mem_reg_write_i, mem_wr_addr_i == ex_rs_addr_i and mem_wr_addr_i != 0.
- Otherwise fwd_src1_o = 10 if the same three conditions hold for the WB stage.
- Otherwise fwd_src1_o = 00.
- fwd_src2_o is identical, using ex_rt_addr_i.
- Register 0 is never forwarded. EX/MEM has priority over MEM/WB.

Load-use hazard (lu), all of the following true:
- ex_mem_read_i and ex_reg_write_i;
- ex_wr_addr_i != 0;
- (id_uses_rs_i and ex_wr_addr_i == id_rs_addr_i) or (id_uses_rt_i and ex_wr_addr_i == id_rt_addr_i).

Multi-cycle sequencer, states IDLE and BUSY, with a down-counter cnt of width clog2(MULTI_LAT):
- IDLE, ex_multi_i=1: stall; go to BUSY with cnt = MULTI_LAT-2. If MULTI_LAT=2, cnt=0.
- BUSY, cnt != 0: stall; cnt decrements.
- BUSY, cnt == 0: release (no stall); ex_done_o=1; go to IDLE.
- Multi-cycle stall outputs: pc_write_o=0, ifid_write_o=0, idex_hold_o=1, exmem_bubble_o=1.

Load-use stall outputs:
- Applied only when lu=1 and no multi-cycle stall is active.
- pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.

Taken branch (highest priority):
- ifid_flush_o=1, idex_flush_o=1, exmem_flush_o=1.
- pc_write_o=1, ifid_write_o=1; all stall, hold and bubble outputs are 0.
- The FSM is forced to IDLE and cnt to 0; the op in EX is wrong-path.
- ex_done_o=0.

Priority order: branch > multi-cycle > load-use.

Counters:
- stall_cnt_o increments in every cycle with pc_write_o=0.
- flush_cnt_o increments in every cycle with branch_taken_i=1.
- Both saturate at all-ones.

## Timing
- Forwarding, stall, flush and bubble outputs are combinational from the inputs and current state, valid in the same cycle.
- A multi-cycle op occupies EX for exactly MULTI_LAT cycles and inserts MULTI_LAT-1 stall cycles.
- ex_done_o pulses in the MULTI_LAT-th cycle.
- Back-to-back multi-cycle ops: after release, ID/EX advances. If the new instruction has ex_multi_i=1, the next IDLE cycle starts a new sequence with no gap.
- A load-use stall lasts exactly one cycle. The following cycle sees a bubble in EX, so lu drops.
- While rst_i=1:
  - pc_write_o=1, ifid_write_o=1;
  - all flush, bubble and hold outputs 0; fwd selects 00; busy_o=0; ex_done_o=0.
  - At the next edge: state IDLE, cnt 0, both counters 0.
- Reset asserted mid-BUSY aborts the sequence; no ex_done_o is produced.

## Test plan
- EX/MEM writes r8 and WB writes r8; EX rs=r8 -> fwd_src1_o=01. Destination r0 with reg_write=1 -> 00.
- Load to r9 in EX, ID rt=r9 with id_uses_rt_i=1 -> one cycle with pc_write_o=0 and idex_bubble_o=1; stall_cnt_o goes 0 to 1.
- MULTI_LAT=4, ex_multi_i held 1 -> busy_o high for 3 cycles, stall for 3 cycles, ex_done_o in cycle 4; stall_cnt_o=3.
- branch_taken_i in the 2nd BUSY cycle -> all three flushes high, pc_write_o=1, FSM IDLE next cycle, no ex_done_o, flush_cnt_o=1.
- Branch and load-use in the same cycle -> flushes only, no stall.
- CNT_W=2, force 5 stall cycles -> stall_cnt_o saturates at 3. rst_i pulse mid-BUSY -> counters 0, busy_o=0.
